// File: rtl/mips_pkg.sv
// mips_pkg: shared state codes, opcode/funct constants and aluop codes for the multicycle controller
// MC_ADDI_EN adds the ADDIEX/ADDIWB states for addi
package mips_pkg;
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
`ifdef MC_ADDI_EN
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
`endif
        JUMP    = 4'd11
    } state_t;
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;
    function automatic logic funct_legal(input logic [5:0] f);
        return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and flags in, datapath strobes and selects out
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, irwrite, regwrite, memwrite, lord, alusrca, regdst, memtoreg;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal;
    modport master(
        input  op, funct, zero,
        output pcen, irwrite, regwrite, memwrite, lord, alusrca, regdst, memtoreg,
               pcsrc, alusrcb, alucontrol, state, illegal
    );
    modport slave(
        output op, funct, zero,
        input  pcen, irwrite, regwrite, memwrite, lord, alusrca, regdst, memtoreg,
               pcsrc, alusrcb, alucontrol, state, illegal
    );
endinterface

// File: rtl/aludec.sv
// aludec: maps aluop and R-type funct to the 3-bit ALU operation
module aludec
    import mips_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);
    logic [2:0] fdec;
    always_comb begin
        fdec = funct == F_SUB ? 3'b110 :
               funct == F_AND ? 3'b000 :
               funct == F_OR  ? 3'b001 :
               funct == F_SLT ? 3'b111 : 3'b010;
        alucontrol = aluop == ALUOP_SUB   ? 3'b110 :
                     aluop == ALUOP_FUNCT ? fdec : 3'b010;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing a multicycle MIPS datapath
// MC_ADDI_EN enables the addi path; otherwise addi decodes as illegal
module multicycle_controller
    import mips_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);
    state_t state_q, state_d;
    logic   illegal_q;
    logic   pcwrite, branch, irwrite, regwrite, memwrite;
    aluop_t aluop;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= state_q == DECODE && state_d == FETCH;
        end
    end
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (bus.op == OP_LW || bus.op == OP_SW)               ? MEMADR  :
                               (bus.op == OP_RTYPE && funct_legal(bus.funct))     ? EXECUTE :
                               bus.op == OP_BEQ                                   ? BRANCH  :
`ifdef MC_ADDI_EN
                               bus.op == OP_ADDI                                  ? ADDIEX  :
`endif
                               bus.op == OP_J                                     ? JUMP    : FETCH;
            MEMADR:  state_d = bus.op == OP_LW ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
`ifdef MC_ADDI_EN
            ADDIEX:  state_d = ADDIWB;
`endif
            default: state_d = FETCH;
        endcase
    end
    always_comb begin
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite      = 1'b0;
        regwrite     = 1'b0;
        memwrite     = 1'b0;
        bus.lord     = 1'b0;
        bus.alusrca  = 1'b0;
        bus.regdst   = 1'b0;
        bus.memtoreg = 1'b0;
        bus.pcsrc    = 2'b00;
        bus.alusrcb  = 2'b00;
        aluop        = ALUOP_ADD;
        case (state_q)
            FETCH:   begin irwrite = 1'b1; pcwrite = 1'b1; bus.alusrcb = 2'b01; end
            DECODE:  bus.alusrcb = 2'b11;
            MEMADR:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
            MEMRD:   bus.lord = 1'b1;
            MEMWB:   begin bus.memtoreg = 1'b1; regwrite = 1'b1; end
            MEMWR:   begin bus.lord = 1'b1; memwrite = 1'b1; end
            EXECUTE: begin bus.alusrca = 1'b1; aluop = ALUOP_FUNCT; end
            ALUWB:   begin bus.regdst = 1'b1; regwrite = 1'b1; end
            BRANCH:  begin bus.alusrca = 1'b1; aluop = ALUOP_SUB; bus.pcsrc = 2'b01; branch = 1'b1; end
`ifdef MC_ADDI_EN
            ADDIEX:  begin bus.alusrca = 1'b1; bus.alusrcb = 2'b10; end
            ADDIWB:  regwrite = 1'b1;
`endif
            JUMP:    begin bus.pcsrc = 2'b10; pcwrite = 1'b1; end
            default: ;
        endcase
    end
    // write strobes are gated by reset so an abort cannot leak a write
    assign bus.pcen     = reset & (pcwrite | (branch & bus.zero));
    assign bus.irwrite  = reset & irwrite;
    assign bus.regwrite = reset & regwrite;
    assign bus.memwrite = reset & memwrite;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;
    aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (bus.alucontrol)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-scenario checks of the multicycle controller
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.op = 6'b000000; bus.funct = 6'b000000; bus.zero = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.illegal, bus.alusrcb} !== {4'd0, 5'b00000, 2'b01}) begin
                miscompares++;
                $display("FAIL reset_hold got=%b want=%b", {bus.state, bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.illegal, bus.alusrcb}, {4'd0, 5'b00000, 2'b01});
            end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.state, bus.irwrite, bus.pcen} !== {4'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL reset_release got=%b want=%b", {bus.state, bus.irwrite, bus.pcen}, {4'd0, 2'b11});
        end
    endtask

    task automatic test_lw();
        bus.op = 6'b100011;
        vectors++;
        if ({bus.state, bus.alusrcb, bus.alucontrol} !== {4'd0, 2'b01, 3'b010}) begin
            miscompares++;
            $display("FAIL lw_fetch got=%b want=%b", {bus.state, bus.alusrcb, bus.alucontrol}, {4'd0, 2'b01, 3'b010});
        end
        step();
        vectors++;
        if ({bus.state, bus.alusrcb, bus.irwrite} !== {4'd1, 2'b11, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_decode got=%b want=%b", {bus.state, bus.alusrcb, bus.irwrite}, {4'd1, 2'b11, 1'b0});
        end
        step();
        vectors++;
        if ({bus.state, bus.alusrca, bus.alusrcb} !== {4'd2, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL lw_memadr got=%b want=%b", {bus.state, bus.alusrca, bus.alusrcb}, {4'd2, 1'b1, 2'b10});
        end
        step();
        vectors++;
        if ({bus.state, bus.lord, bus.memwrite, bus.regwrite} !== {4'd3, 3'b100}) begin
            miscompares++;
            $display("FAIL lw_memrd got=%b want=%b", {bus.state, bus.lord, bus.memwrite, bus.regwrite}, {4'd3, 3'b100});
        end
        step();
        vectors++;
        if ({bus.state, bus.memtoreg, bus.regwrite} !== {4'd4, 2'b11}) begin
            miscompares++;
            $display("FAIL lw_memwb got=%b want=%b", {bus.state, bus.memtoreg, bus.regwrite}, {4'd4, 2'b11});
        end
        step();
        vectors++;
        if ({bus.state, bus.illegal} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL lw_done got=%b want=%b", {bus.state, bus.illegal}, {4'd0, 1'b0});
        end
    endtask

    task automatic test_sw();
        bus.op = 6'b101011;
        step();
        step();
        step();
        vectors++;
        if ({bus.state, bus.lord, bus.memwrite, bus.regwrite} !== {4'd5, 3'b110}) begin
            miscompares++;
            $display("FAIL sw_memwr got=%b want=%b", {bus.state, bus.lord, bus.memwrite, bus.regwrite}, {4'd5, 3'b110});
        end
        step();
        vectors++;
        if (bus.state !== 4'd0) begin
            miscompares++;
            $display("FAIL sw_done got=%0d want=0", bus.state);
        end
    endtask

    task automatic test_rtype_alu();
        logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ac [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int i = 0; i < 5; i++) begin
            bus.op = 6'b000000;
            bus.funct = fn[i];
            step();
            step();
            vectors++;
            if ({bus.state, bus.alucontrol, bus.alusrca} !== {4'd6, ac[i], 1'b1}) begin
                miscompares++;
                $display("FAIL rtype_execute funct=%b got=%b want=%b", fn[i], {bus.state, bus.alucontrol, bus.alusrca}, {4'd6, ac[i], 1'b1});
            end
            step();
            vectors++;
            if ({bus.state, bus.regdst, bus.regwrite} !== {4'd7, 2'b11}) begin
                miscompares++;
                $display("FAIL rtype_aluwb funct=%b got=%b want=%b", fn[i], {bus.state, bus.regdst, bus.regwrite}, {4'd7, 2'b11});
            end
            step();
            vectors++;
            if ({bus.state, bus.illegal} !== {4'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL rtype_done funct=%b got=%b want=%b", fn[i], {bus.state, bus.illegal}, {4'd0, 1'b0});
            end
        end
    endtask

    task automatic test_illegal_then_jump();
        bus.op = 6'b000000;
        bus.funct = 6'b100111;
        step();
        vectors++;
        if ({bus.state, bus.illegal} !== {4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_decode got=%b want=%b", {bus.state, bus.illegal}, {4'd1, 1'b0});
        end
        step();
        vectors++;
        if ({bus.state, bus.illegal, bus.irwrite, bus.regwrite} !== {4'd0, 3'b110}) begin
            miscompares++;
            $display("FAIL illegal_pulse got=%b want=%b", {bus.state, bus.illegal, bus.irwrite, bus.regwrite}, {4'd0, 3'b110});
        end
        bus.op = 6'b000010;
        step();
        vectors++;
        if ({bus.state, bus.illegal} !== {4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_one_cycle got=%b want=%b", {bus.state, bus.illegal}, {4'd1, 1'b0});
        end
        step();
        vectors++;
        if ({bus.state, bus.pcsrc, bus.pcen} !== {4'd11, 2'b10, 1'b1}) begin
            miscompares++;
            $display("FAIL jump got=%b want=%b", {bus.state, bus.pcsrc, bus.pcen}, {4'd11, 2'b10, 1'b1});
        end
        step();
        vectors++;
        if (bus.state !== 4'd0) begin
            miscompares++;
            $display("FAIL jump_done got=%0d want=0", bus.state);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            bus.op = 6'b000100;
            bus.zero = z[0];
            step();
            step();
            vectors++;
            if ({bus.state, bus.pcen, bus.pcsrc, bus.alucontrol, bus.alusrca} !== {4'd8, z[0], 2'b01, 3'b110, 1'b1}) begin
                miscompares++;
                $display("FAIL beq_zero%0d got=%b want=%b", z, {bus.state, bus.pcen, bus.pcsrc, bus.alucontrol, bus.alusrca}, {4'd8, z[0], 2'b01, 3'b110, 1'b1});
            end
            step();
            vectors++;
            if (bus.state !== 4'd0) begin
                miscompares++;
                $display("FAIL beq_done got=%0d want=0", bus.state);
            end
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_addi();
        bus.op = 6'b001000;
        step();
        vectors++;
        if (bus.state !== 4'd1) begin
            miscompares++;
            $display("FAIL addi_decode got=%0d want=1", bus.state);
        end
        step();
`ifdef MC_ADDI_EN
        vectors++;
        if ({bus.state, bus.alusrca, bus.alusrcb} !== {4'd9, 1'b1, 2'b10}) begin
            miscompares++;
            $display("FAIL addi_ex got=%b want=%b", {bus.state, bus.alusrca, bus.alusrcb}, {4'd9, 1'b1, 2'b10});
        end
        step();
        vectors++;
        if ({bus.state, bus.regwrite, bus.regdst, bus.memtoreg} !== {4'd10, 3'b100}) begin
            miscompares++;
            $display("FAIL addi_wb got=%b want=%b", {bus.state, bus.regwrite, bus.regdst, bus.memtoreg}, {4'd10, 3'b100});
        end
        step();
        vectors++;
        if ({bus.state, bus.illegal} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL addi_done got=%b want=%b", {bus.state, bus.illegal}, {4'd0, 1'b0});
        end
`else
        vectors++;
        if ({bus.state, bus.illegal, bus.regwrite} !== {4'd0, 2'b10}) begin
            miscompares++;
            $display("FAIL addi_illegal got=%b want=%b", {bus.state, bus.illegal, bus.regwrite}, {4'd0, 2'b10});
        end
`endif
    endtask

    task automatic test_sw_abort();
        bus.op = 6'b101011;
        step();
        step();
        vectors++;
        if ({bus.state, bus.memwrite} !== {4'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL abort_memadr got=%b want=%b", {bus.state, bus.memwrite}, {4'd2, 1'b0});
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.state, bus.memwrite, bus.pcen, bus.irwrite, bus.regwrite} !== {4'd0, 4'b0000}) begin
            miscompares++;
            $display("FAIL abort_immediate got=%b want=%b", {bus.state, bus.memwrite, bus.pcen, bus.irwrite, bus.regwrite}, {4'd0, 4'b0000});
        end
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({bus.state, bus.memwrite} !== {4'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL abort_hold got=%b want=%b", {bus.state, bus.memwrite}, {4'd0, 1'b0});
            end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.state, bus.irwrite, bus.pcen} !== {4'd0, 2'b11}) begin
            miscompares++;
            $display("FAIL abort_release got=%b want=%b", {bus.state, bus.irwrite, bus.pcen}, {4'd0, 2'b11});
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (bus.memwrite !== 1'b0 && bus.state !== 4'd5) begin
                miscompares++;
                $display("FAIL abort_stray_write state=%0d memwrite=%b want=0", bus.state, bus.memwrite);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_alu();
        test_illegal_then_jump();
        test_beq();
        test_addi();
        test_sw_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
